udma_cfg_initiator: RTL and testbench
=====================================

Name: udma_cfg_initiator

Overview:
- Initiator (master) side of the uDMA peripheral configuration bus.
- Sits between a host-side command port (valid/ready) and any cfg-bus responder, such as the camera register interface. It drives `cfg_addr`/`cfg_data`/`cfg_valid`/`cfg_rwn` and waits for `cfg_ready`.
- Returns write acknowledgements and read data on a response port (valid/ready).
- Aborts any access that the responder does not accept within a programmable timeout, and flags it as an error.

Parameters:
- TIMEOUT_CYCLES, 16, maximum number of cycles `cfg_valid_o` stays high without `cfg_ready_i`; 0 disables the timeout.
- CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the internal timeout counter (derived, not overridden).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; one clock; reset is synchronous and active-low
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_rwn_i  in  1  1=read, 0=write
- cmd_addr_i  in  5  register word address
- cmd_data_i  in  32  write data (ignored for reads)
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_data_o  out  32  read data; 0 for writes and errors
- rsp_err_o  out  1  access timed out
- cfg_valid_o  out  1  bus request to responder
- cfg_rwn_o  out  1  bus direction
- cfg_addr_o  out  5  bus address
- cfg_data_o  out  32  bus write data
- cfg_data_i  in  32  bus read data, valid combinationally while cfg_valid_o&cfg_ready_i&cfg_rwn_o
- cfg_ready_i  in  1  responder accepts
- busy_o  out  1  state != IDLE
- timeout_sticky_o  out  1  set on any timeout
- clr_timeout_i  in  1  clears timeout_sticky_o

Behaviour:
- Reset (sampled on posedge while rstn_i=0, overrides everything, including mid-access):
  - state=IDLE.
  - cfg_valid_o=0, cfg_rwn_o=0, cfg_addr_o=0, cfg_data_o=0.
  - rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0.
  - timeout_sticky_o=0, counter=0.
  - The aborted access produces no response.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - cmd_ready_o=1 (combinational from state only); cmd_ready_o=0 in all other states.
  - On cmd_valid_i=1: latch rwn/addr/data into the cfg_* output registers, set cfg_valid_o=1, counter=0, go to ISSUE.
  - Result: command accepted at cycle N gives cfg_valid_o=1 at N+1.
- ISSUE:
  - cfg_valid_o=1; cfg_rwn_o, cfg_addr_o and cfg_data_o are held stable.
  - If cfg_ready_i=1:
    - rsp_data_o <= cfg_rwn_o ? cfg_data_i : 0.
    - rsp_err_o <= 0, rsp_valid_o <= 1, cfg_valid_o <= 0, go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1:
    - rsp_data_o <= 0, rsp_err_o <= 1, rsp_valid_o <= 1, cfg_valid_o <= 0.
    - timeout_sticky_o <= 1, go to RESP.
  - Else counter++.
  - Ready takes priority over timeout in the same cycle.
  - cfg_valid_o is therefore high for at most TIMEOUT_CYCLES cycles.
- RESP:
  - rsp_valid_o=1; rsp_data_o and rsp_err_o are held stable until rsp_ready_i=1.
  - On rsp_ready_i=1: rsp_valid_o <= 0, go to IDLE.
  - No new command is accepted in the same cycle (no bypass).
  - Minimum command period is 3 cycles.
- Best-case latency: accept N, cfg_valid_o N+1 with ready at N+1, rsp_valid_o N+2, cmd_ready_o again at N+3 if rsp_ready_i=1 at N+2.
- timeout_sticky_o:
  - Set-priority: if a timeout occurs in the same cycle as clr_timeout_i, the flag stays 1.
  - Otherwise clr_timeout_i=1 clears it the next cycle.
  - The flag is independent of the FSM state.
- Reads capture cfg_data_i only in the ready cycle; values on cfg_data_i at any other time are ignored.
- Writes with cfg_ready_i=1 in the first ISSUE cycle complete in one bus cycle.
- busy_o = (state != IDLE), combinational.

Test Plan:
- Write, always-ready responder: cmd write addr 5'h08, data 32'h0000_0055 -> exactly one cycle of cfg_valid_o=1, cfg_rwn_o=0, addr 08, data 55; rsp_valid_o two cycles after accept with rsp_data_o=0 and rsp_err_o=0.
- Read: responder returns 32'hA5A5_0003 for addr 5'h02 -> rsp_data_o=32'hA5A5_0003, rsp_err_o=0; cmd_ready_o low from accept until the cycle after the response handshake.
- Wait states: cfg_ready_i held low for 5 cycles, TIMEOUT_CYCLES=16 -> cfg_valid_o high for 6 cycles with addr/data stable; normal response.
- Timeout: cfg_ready_i stuck at 0 with TIMEOUT_CYCLES=16 -> cfg_valid_o high exactly 16 cycles, then rsp_err_o=1, rsp_data_o=0, timeout_sticky_o=1.
- Timeout edge: ready asserted in the 16th cycle -> success with rsp_err_o=0. Timeout coinciding with clr_timeout_i -> flag remains 1; a later clr_timeout_i clears it.
- Backpressure and reset: rsp_ready_i held low for 10 cycles -> response held stable, no new cmd accepted. Then rstn_i=0 mid-ISSUE -> next cycle all outputs at reset values and no response is emitted.

Source files
------------

// File: rtl/udma_cfg_initiator.sv
// Initiator side of the uDMA peripheral configuration bus: accepts host commands,
// drives one cfg-bus access at a time, and returns data/ack or a timeout error.
//
// state | meaning
// IDLE  | ready for a host command
// ISSUE | cfg_valid_o high, waiting for cfg_ready_i or timeout
// RESP  | response held until rsp_ready_i
module udma_cfg_initiator #(
  parameter  int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_rwn_i,
  input  logic [4:0]  cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        cfg_valid_o,
  output logic        cfg_rwn_o,
  output logic [4:0]  cfg_addr_o,
  output logic [31:0] cfg_data_o,
  input  logic [31:0] cfg_data_i,
  input  logic        cfg_ready_i,
  output logic        busy_o,
  output logic        timeout_sticky_o,
  input  logic        clr_timeout_i
);

  // With the timeout disabled the counter is unused; keep it at least one bit wide.
  localparam int unsigned CNT_W = (CNT_WIDTH == 0) ? 1 : CNT_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cfg_valid_q, cfg_valid_d;
  logic              cfg_rwn_q, cfg_rwn_d;
  logic [4:0]        cfg_addr_q, cfg_addr_d;
  logic [31:0]       cfg_data_q, cfg_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              sticky_q, sticky_d;
  logic              timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_valid_d = cfg_valid_q;
    cfg_rwn_d   = cfg_rwn_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    sticky_d    = clr_timeout_i ? 1'b0 : sticky_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          cfg_valid_d = 1'b1;
          cfg_rwn_d   = cmd_rwn_i;
          cfg_addr_d  = cmd_addr_i;
          cfg_data_d  = cmd_data_i;
          cnt_d       = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // Ready wins over a timeout landing in the same cycle.
        if (cfg_ready_i) begin
          rsp_data_d  = cfg_rwn_q ? cfg_data_i : 32'h0;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          cfg_valid_d = 1'b0;
          state_d     = RESP;
        end else if (timeout_hit) begin
          rsp_data_d  = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          cfg_valid_d = 1'b0;
          sticky_d    = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cfg_valid_q <= 1'b0;
      cfg_rwn_q   <= 1'b0;
      cfg_addr_q  <= 5'h0;
      cfg_data_q  <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_rwn_q   <= cfg_rwn_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      sticky_q    <= sticky_d;
    end
  end

  assign cmd_ready_o      = (state_q == IDLE);
  assign busy_o           = (state_q != IDLE);
  assign cfg_valid_o      = cfg_valid_q;
  assign cfg_rwn_o        = cfg_rwn_q;
  assign cfg_addr_o       = cfg_addr_q;
  assign cfg_data_o       = cfg_data_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_data_o       = rsp_data_q;
  assign rsp_err_o        = rsp_err_q;
  assign timeout_sticky_o = sticky_q;

endmodule

// File: tb/tb_udma_cfg_initiator.sv
// Bench for udma_cfg_initiator: directed and randomized transactions checked
// against a transaction-level model (wait count -> bus cycles, error, data).
module tb_udma_cfg_initiator;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_rwn_i;
  logic [4:0]  cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_data_o;
  logic        cfg_valid_o, cfg_rwn_o, cfg_ready_i;
  logic [4:0]  cfg_addr_o;
  logic [31:0] cfg_data_o, cfg_data_i;
  logic        busy_o, timeout_sticky_o, clr_timeout_i;

  int n_tests = 0;
  int n_fail  = 0;
  bit sticky_exp = 1'b0;

  udma_cfg_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_rwn_i(cmd_rwn_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o), .cfg_addr_o(cfg_addr_o),
    .cfg_data_o(cfg_data_o), .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i),
    .busy_o(busy_o), .timeout_sticky_o(timeout_sticky_o), .clr_timeout_i(clr_timeout_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One host transaction. wait_cyc = ISSUE cycles before the responder says ready
  // (>= TO means never); bp = cycles of response backpressure; clr_k = ISSUE
  // cycle index in which clr_timeout_i pulses (-1 for none).
  task automatic do_txn(input logic rwn, input logic [4:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int wait_cyc, input int bp,
                        input int clr_k, input string name);
    bit          exp_to;
    int          exp_cyc, k;
    logic [31:0] exp_data;
    exp_to   = (wait_cyc >= TO);
    exp_cyc  = exp_to ? TO : wait_cyc + 1;
    exp_data = (!exp_to && rwn) ? rdata : 32'h0;
    if (exp_to) sticky_exp = 1'b1;
    else if (clr_k >= 0 && clr_k < exp_cyc) sticky_exp = 1'b0;

    n_tests++;
    if (cmd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL %s cmd_ready_before: got %b want 1", name, cmd_ready_o);
    end
    cmd_valid_i = 1'b1; cmd_rwn_i = rwn; cmd_addr_i = addr; cmd_data_i = wdata;
    @(negedge clk_i);
    cmd_valid_i = 1'b0; cmd_data_i = $urandom; cmd_addr_i = 5'($urandom);

    k = 0;
    while (cfg_valid_o === 1'b1 && k < 40) begin
      n_tests++;
      if (cfg_rwn_o !== rwn || cfg_addr_o !== addr || cfg_data_o !== wdata ||
          cmd_ready_o !== 1'b0 || busy_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s issue_cycle%0d: rwn=%b addr=%h data=%h cmd_rdy=%b busy=%b rsp_v=%b want rwn=%b addr=%h data=%h 0 1 0",
                 name, k, cfg_rwn_o, cfg_addr_o, cfg_data_o, cmd_ready_o, busy_o, rsp_valid_o,
                 rwn, addr, wdata);
      end
      cfg_ready_i   = (k == wait_cyc);
      cfg_data_i    = (k == wait_cyc) ? rdata : $urandom;
      clr_timeout_i = (k == clr_k);
      @(negedge clk_i);
      k++;
    end
    cfg_ready_i = 1'b0; clr_timeout_i = 1'b0; cfg_data_i = $urandom;

    n_tests++;
    if (k != exp_cyc) begin
      n_fail++; $display("FAIL %s valid_cycles: got %0d want %0d", name, k, exp_cyc);
    end
    n_tests++;
    if (rsp_valid_o !== 1'b1 || rsp_err_o !== exp_to || rsp_data_o !== exp_data) begin
      n_fail++;
      $display("FAIL %s response: valid=%b err=%b data=%h want 1 %b %h",
               name, rsp_valid_o, rsp_err_o, rsp_data_o, exp_to, exp_data);
    end
    n_tests++;
    if (timeout_sticky_o !== sticky_exp) begin
      n_fail++; $display("FAIL %s sticky: got %b want %b", name, timeout_sticky_o, sticky_exp);
    end

    for (int i = 0; i < bp; i++) begin
      cmd_valid_i = 1'b1; cmd_rwn_i = ~rwn; cmd_addr_i = ~addr;
      @(negedge clk_i);
      n_tests++;
      if (rsp_valid_o !== 1'b1 || rsp_err_o !== exp_to || rsp_data_o !== exp_data ||
          cmd_ready_o !== 1'b0 || cfg_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s backpressure%0d: valid=%b err=%b data=%h cmd_rdy=%b cfg_v=%b want 1 %b %h 0 0",
                 name, i, rsp_valid_o, rsp_err_o, rsp_data_o, cmd_ready_o, cfg_valid_o, exp_to, exp_data);
      end
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0; cmd_valid_i = 1'b0;
    n_tests++;
    if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || cfg_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_handshake: rsp_v=%b cmd_rdy=%b busy=%b cfg_v=%b want 0 1 0 0",
               name, rsp_valid_o, cmd_ready_o, busy_o, cfg_valid_o);
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    sticky_exp = 1'b0;
    n_tests++;
    if (cfg_valid_o !== 0 || cfg_rwn_o !== 0 || cfg_addr_o !== 0 || cfg_data_o !== 0 ||
        rsp_valid_o !== 0 || rsp_data_o !== 0 || rsp_err_o !== 0 || timeout_sticky_o !== 0 ||
        cmd_ready_o !== 1 || busy_o !== 0) begin
      n_fail++;
      $display("FAIL reset_state: cfg_v=%b rwn=%b addr=%h data=%h rsp_v=%b rdata=%h err=%b sticky=%b cmd_rdy=%b busy=%b want all 0 except cmd_rdy=1",
               cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o, rsp_valid_o, rsp_data_o,
               rsp_err_o, timeout_sticky_o, cmd_ready_o, busy_o);
    end
  endtask

  task automatic test_write();
    do_txn(1'b0, 5'h08, 32'h0000_0055, 32'hDEAD_BEEF, 0, 0, -1, "write");
  endtask

  task automatic test_read();
    do_txn(1'b1, 5'h02, 32'h1234_5678, 32'hA5A5_0003, 0, 1, -1, "read");
  endtask

  task automatic test_wait_states();
    do_txn(1'b1, 5'h11, 32'h0, 32'h0BAD_F00D, 5, 0, -1, "wait5_read");
    do_txn(1'b0, 5'h1F, 32'hCAFE_0001, 32'h0, 5, 2, -1, "wait5_write");
  endtask

  task automatic test_timeout();
    do_txn(1'b1, 5'h03, 32'h0, 32'h7777_7777, 100, 0, -1, "timeout");
  endtask

  task automatic test_timeout_edge();
    do_txn(1'b1, 5'h04, 32'h0, 32'h1357_9BDF, TO - 1, 0, -1, "ready_in_last_cycle");
    do_txn(1'b0, 5'h05, 32'h2468_ACE0, 32'h0, 100, 0, TO - 1, "timeout_with_clr");
    clr_timeout_i = 1'b1;
    @(negedge clk_i);
    clr_timeout_i = 1'b0;
    sticky_exp = 1'b0;
    n_tests++;
    if (timeout_sticky_o !== 1'b0) begin
      n_fail++; $display("FAIL sticky_clear: got %b want 0", timeout_sticky_o);
    end
    do_txn(1'b0, 5'h06, 32'h0000_0001, 32'h0, 3, 0, 1, "clr_no_timeout");
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      do_txn(1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), -1, "random");
    end
  endtask

  task automatic test_backpressure_reset();
    int seen;
    do_txn(1'b1, 5'h09, 32'h0, 32'h5A5A_1234, 2, 10, -1, "backpressure10");
    cmd_valid_i = 1'b1; cmd_rwn_i = 1'b1; cmd_addr_i = 5'h0A; cmd_data_i = 32'hFFFF_0000;
    @(negedge clk_i);
    cmd_valid_i = 1'b0; cfg_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    sticky_exp = 1'b0;
    n_tests++;
    if (cfg_valid_o !== 0 || cfg_rwn_o !== 0 || cfg_addr_o !== 0 || cfg_data_o !== 0 ||
        rsp_valid_o !== 0 || rsp_data_o !== 0 || rsp_err_o !== 0 || timeout_sticky_o !== 0 ||
        cmd_ready_o !== 1 || busy_o !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_issue: cfg_v=%b rwn=%b addr=%h data=%h rsp_v=%b rdata=%h err=%b sticky=%b cmd_rdy=%b busy=%b want all 0 except cmd_rdy=1",
               cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o, rsp_valid_o, rsp_data_o,
               rsp_err_o, timeout_sticky_o, cmd_ready_o, busy_o);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b0 || cfg_valid_o !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL no_rsp_after_reset: active cycles %0d want 0", seen);
    end
    do_txn(1'b0, 5'h0B, 32'h0000_00AA, 32'h0, 0, 0, -1, "after_reset");
  endtask

  initial begin
    rstn_i = 1'b0; cmd_valid_i = 1'b0; cmd_rwn_i = 1'b0; cmd_addr_i = 5'h0;
    cmd_data_i = 32'h0; rsp_ready_i = 1'b0; cfg_data_i = 32'h0; cfg_ready_i = 1'b0;
    clr_timeout_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_timeout();
    test_timeout_edge();
    test_random();
    test_backpressure_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
